// File: rtl/hazard_dest_tracker_pkg.sv
// Shared definitions for the hazard/destination tracker: FSM encodings,
// stage field layouts, bubble constants and the load-use compare.
package hazard_dest_tracker_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } fsmState_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } idExFields_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } exMemFields_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
  } memWbFields_t;

  // A bubble is an all-zero stage: no destination, no write, no load.
  localparam idExFields_t  ID_EX_BUBBLE  = '0;
  localparam exMemFields_t EX_MEM_BUBBLE = '0;
  localparam memWbFields_t MEM_WB_BUBBLE = '0;

  // A load in ID/EX whose destination is read by the instruction in ID.
  // Register 0 is never a real dependency, so it never stalls.
  function automatic logic isLoadUse(
    input idExFields_t idEx,
    input logic        idValid,
    input logic [4:0]  idRs,
    input logic [4:0]  idRt,
    input logic        idUsesRt
  );
    return idEx.mr && (idEx.rd != REG_ZERO) && idValid &&
           ((idEx.rd == idRs) || (idUsesRt && (idEx.rd == idRt)));
  endfunction

endpackage

// File: rtl/hazard_dest_tracker_if.sv
// Bundle between the decode stage / memory side and the tracker.
// master drives the ID-stage fields, flush and mem_ready; slave is the tracker.
interface hazard_dest_tracker_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             mem_ready;

  logic [4:0]       ID_EX_RegisterRs;
  logic [4:0]       ID_EX_RegisterRt;
  logic [4:0]       EX_MEM_RegisterRd;
  logic             EX_MEM_RegWrite;
  logic [4:0]       MEM_WB_RegisterRd;
  logic             MEM_WB_RegWrite;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic [CNT_W-1:0] stall_count;
  logic             mem_error;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
           flush, mem_ready,
    input  ID_EX_RegisterRs, ID_EX_RegisterRt, EX_MEM_RegisterRd, EX_MEM_RegWrite,
           MEM_WB_RegisterRd, MEM_WB_RegWrite, PC_Write, IF_ID_Write,
           stall_count, mem_error
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
           flush, mem_ready,
    output ID_EX_RegisterRs, ID_EX_RegisterRt, EX_MEM_RegisterRd, EX_MEM_RegWrite,
           MEM_WB_RegisterRd, MEM_WB_RegWrite, PC_Write, IF_ID_Write,
           stall_count, mem_error
  );

endinterface

// File: rtl/hazard_dest_tracker_stage_reg.sv
// One pipeline stage register: loads on advance (zeros when bubble is set),
// otherwise holds. A bubble is all-zero for every stage layout.
module dest_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Stage contents: reset to empty, load or bubble on advance, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (advance) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Carries destination/write-enable info through ID/EX, EX/MEM and MEM/WB,
// inserts load-use bubbles and freezes the pipe while a load awaits memory.
module hazard_dest_tracker
  import hazard_dest_tracker_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_dest_tracker_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The wait cycle that gives up on the memory ack and lets the load retire.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

  fsmState_t         stateReg;
  logic [WAIT_W-1:0] waitCntReg;
  logic              memErrorReg;
  logic [CNT_W-1:0]  stallCountReg;

  idExFields_t  idExD, idExQ;
  exMemFields_t exMemQ;
  memWbFields_t memWbQ;

  logic loadUse;
  logic waitDone;
  logic freeze;
  logic idExBubble;
  logic stallPc;

  // Stall/advance decisions are combinational so the stall takes effect this cycle.
  always_comb begin
    idExD      = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                   rw: bus.id_reg_write, mr: bus.id_mem_read};
    loadUse    = isLoadUse(idExQ, bus.id_valid, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    waitDone   = bus.mem_ready || (waitCntReg == LAST_WAIT);
    if (stateReg == ST_RUN) begin
      freeze = exMemQ.mr && !bus.mem_ready;
    end else begin
      freeze = !waitDone;
    end
    // flush squashes the ID instruction, so a load-use on it is moot.
    idExBubble = bus.flush || loadUse || !bus.id_valid;
    stallPc    = freeze || (!bus.flush && loadUse);
  end

  dest_stage_reg #(.W($bits(idExFields_t))) idExStage (
    .clk     (clk),
    .rst     (rst),
    .advance (!freeze),
    .bubble  (idExBubble),
    .d       (idExD),
    .q       (idExQ)
  );

  dest_stage_reg #(.W($bits(exMemFields_t))) exMemStage (
    .clk     (clk),
    .rst     (rst),
    .advance (!freeze),
    .bubble  (1'b0),
    .d       (exMemFields_t'({idExQ.rd, idExQ.rw, idExQ.mr})),
    .q       (exMemQ)
  );

  dest_stage_reg #(.W($bits(memWbFields_t))) memWbStage (
    .clk     (clk),
    .rst     (rst),
    .advance (!freeze),
    .bubble  (1'b0),
    .d       (memWbFields_t'({exMemQ.rd, exMemQ.rw})),
    .q       (memWbQ)
  );

  // Memory-wait FSM: enter on an unacked load, leave on ack or timeout (which is sticky).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= ST_RUN;
      waitCntReg  <= '0;
      memErrorReg <= 1'b0;
    end else begin
      case (stateReg)
        ST_RUN: begin
          if (exMemQ.mr && !bus.mem_ready) begin
            stateReg   <= ST_MEM_WAIT;
            waitCntReg <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            stateReg <= ST_RUN;
          end else if (waitCntReg == LAST_WAIT) begin
            stateReg    <= ST_RUN;
            memErrorReg <= 1'b1;
          end else begin
            waitCntReg <= waitCntReg + 1'b1;
          end
        end
        default: stateReg <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCountReg <= '0;
    end else if (stallPc && (stallCountReg != '1)) begin
      stallCountReg <= stallCountReg + 1'b1;
    end
  end

  assign bus.ID_EX_RegisterRs  = idExQ.rs;
  assign bus.ID_EX_RegisterRt  = idExQ.rt;
  assign bus.EX_MEM_RegisterRd = exMemQ.rd;
  assign bus.EX_MEM_RegWrite   = exMemQ.rw;
  assign bus.MEM_WB_RegisterRd = memWbQ.rd;
  assign bus.MEM_WB_RegWrite   = memWbQ.rw;
  assign bus.PC_Write          = !stallPc;
  assign bus.IF_ID_Write       = !stallPc;
  assign bus.stall_count       = stallCountReg;
  assign bus.mem_error         = memErrorReg;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Directed scenarios followed by random traffic, all checked against a
// cycle-level reference model of the stall/forwarding rules.
module tb_hazard_dest_tracker;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = 65535;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic lastPcw;

  hazard_dest_tracker_if #(.CNT_W(CNT_W)) bus();

  hazard_dest_tracker #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: plain integers per pipeline field.
  int mIdRs, mIdRt, mIdRd, mIdRw, mIdMr;
  int mExRd, mExRw, mExMr;
  int mWbRd, mWbRw;
  int mWaiting, mWaited, mErr, mStalls;

  task automatic mReset();
    mIdRs = 0; mIdRt = 0; mIdRd = 0; mIdRw = 0; mIdMr = 0;
    mExRd = 0; mExRw = 0; mExMr = 0;
    mWbRd = 0; mWbRw = 0;
    mWaiting = 0; mWaited = 0; mErr = 0; mStalls = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("id_ex_rs",   32'(bus.ID_EX_RegisterRs),  mIdRs);
    chk("id_ex_rt",   32'(bus.ID_EX_RegisterRt),  mIdRt);
    chk("ex_mem_rd",  32'(bus.EX_MEM_RegisterRd), mExRd);
    chk("ex_mem_rw",  32'(bus.EX_MEM_RegWrite),   mExRw);
    chk("mem_wb_rd",  32'(bus.MEM_WB_RegisterRd), mWbRd);
    chk("mem_wb_rw",  32'(bus.MEM_WB_RegWrite),   mWbRw);
    chk("stall_count", 32'(bus.stall_count),      mStalls);
    chk("mem_error",  32'(bus.mem_error),         mErr);
  endtask

  task automatic setId(input bit v, input int rs, input int rt, input bit ut,
                       input int rd, input bit rw, input bit mr);
    bus.id_valid     = v;
    bus.id_rs        = 5'(rs);
    bus.id_rt        = 5'(rt);
    bus.id_uses_rt   = ut;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  // One clock: check the same-cycle stall outputs, clock, advance the model, check state.
  task automatic cycle();
    bit luse, freeze, pcw;
    #1;
    luse = (mIdMr != 0) && (mIdRd != 0) && bus.id_valid &&
           ((mIdRd == int'(bus.id_rs)) || (bus.id_uses_rt && (mIdRd == int'(bus.id_rt))));
    if (mWaiting == 0) freeze = (mExMr != 0) && !bus.mem_ready;
    else               freeze = !bus.mem_ready && (mWaited < MEM_TIMEOUT - 1);
    pcw = !freeze && (bus.flush || !luse);
    lastPcw = bus.PC_Write;
    chk("pc_write",    32'(bus.PC_Write),    32'(pcw));
    chk("if_id_write", 32'(bus.IF_ID_Write), 32'(pcw));
    @(posedge clk);
    if (!pcw && mStalls < CNT_MAX) mStalls++;
    if (freeze) begin
      if (mWaiting == 0) begin mWaiting = 1; mWaited = 0; end
      else mWaited++;
    end else begin
      if (mWaiting != 0 && !bus.mem_ready) mErr = 1;
      mWaiting = 0;
      mWbRd = mExRd; mWbRw = mExRw;
      mExRd = mIdRd; mExRw = mIdRw; mExMr = mIdMr;
      if (!bus.id_valid || bus.flush || luse) begin
        mIdRs = 0; mIdRt = 0; mIdRd = 0; mIdRw = 0; mIdMr = 0;
      end else begin
        mIdRs = bus.id_rs; mIdRt = bus.id_rt; mIdRd = bus.id_rd;
        mIdRw = bus.id_reg_write; mIdMr = bus.id_mem_read;
      end
    end
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic nop();
    setId(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lastPcw = 1'b1;
    mReset();
    rst = 1'b1;
    setId(0, 0, 0, 0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset state.
    #3;
    chk("rst_pc_write", 32'(bus.PC_Write), 1);
    chk("rst_if_id_write", 32'(bus.IF_ID_Write), 1);
    checkAll();
    @(negedge clk);
    rst = 1'b0;

    // 1: lw r8 then add using r8 as rs -> one-cycle stall, then add enters ID/EX.
    setId(1, 1, 2, 1, 8, 1, 1); cycle();
    setId(1, 8, 3, 1, 9, 1, 0); cycle();
    chk("t1_stall_pc", 32'(lastPcw), 0);
    chk("t1_idex_bubble_rs", 32'(bus.ID_EX_RegisterRs), 0);
    chk("t1_exmem_rd", 32'(bus.EX_MEM_RegisterRd), 8);
    chk("t1_exmem_rw", 32'(bus.EX_MEM_RegWrite), 1);
    cycle();
    chk("t1_resume_pc", 32'(lastPcw), 1);
    chk("t1_add_in_idex", 32'(bus.ID_EX_RegisterRs), 8);
    chk("t1_stall_count", 32'(bus.stall_count), 1);

    // 2: rt matches but rt is not a source -> no stall.
    setId(1, 1, 2, 1, 8, 1, 1); cycle();
    setId(1, 2, 8, 0, 10, 1, 0); cycle();
    chk("t2_no_stall", 32'(lastPcw), 1);
    chk("t2_stall_count", 32'(bus.stall_count), 1);

    // 3: lw r5 in EX/MEM with mem_ready low for 3 cycles.
    setId(1, 1, 2, 1, 5, 1, 1); cycle();
    nop(); cycle();
    bus.mem_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("t3_frozen_exmem_rd", 32'(bus.EX_MEM_RegisterRd), 5);
    end
    chk("t3_stall_count", 32'(bus.stall_count), 4);
    bus.mem_ready = 1'b1;
    cycle();
    chk("t3_memwb_rd", 32'(bus.MEM_WB_RegisterRd), 5);
    chk("t3_memwb_rw", 32'(bus.MEM_WB_RegWrite), 1);

    // 4: flush together with load-use -> bubble, PC keeps going.
    setId(1, 1, 2, 1, 7, 1, 1); cycle();
    setId(1, 7, 3, 1, 11, 1, 0); bus.flush = 1'b1; cycle();
    bus.flush = 1'b0;
    chk("t4_pc_write", 32'(lastPcw), 1);
    chk("t4_idex_rs", 32'(bus.ID_EX_RegisterRs), 0);
    chk("t4_stall_count", 32'(bus.stall_count), 4);

    // 5: memory never acks -> timeout after MEM_TIMEOUT wait cycles.
    setId(1, 1, 2, 1, 6, 1, 1); cycle();
    nop(); cycle();
    bus.mem_ready = 1'b0;
    repeat (4) cycle();
    chk("t5_no_error_yet", 32'(bus.mem_error), 0);
    cycle();
    chk("t5_mem_error", 32'(bus.mem_error), 1);
    chk("t5_load_retired", 32'(bus.MEM_WB_RegisterRd), 6);
    chk("t5_stall_count", 32'(bus.stall_count), 8);
    cycle();
    chk("t5_back_to_run", 32'(lastPcw), 1);

    // 6: reset in the middle of a memory wait acts immediately.
    bus.mem_ready = 1'b1;
    setId(1, 1, 2, 1, 4, 1, 1); cycle();
    nop(); cycle();
    bus.mem_ready = 1'b0;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    mReset();
    chk("t6_pc_write", 32'(bus.PC_Write), 1);
    chk("t6_if_id_write", 32'(bus.IF_ID_Write), 1);
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;

    // 7: load to r0 never creates a dependency.
    setId(1, 1, 2, 1, 0, 1, 1); cycle();
    setId(1, 0, 0, 1, 12, 1, 0); cycle();
    chk("t7_no_stall", 32'(lastPcw), 1);
    chk("t7_stall_count", 32'(bus.stall_count), 0);

    // Random traffic over a small register range to make hazards frequent.
    for (int i = 0; i < 600; i++) begin
      setId($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 35);
      bus.flush     = $urandom_range(0, 99) < 10;
      bus.mem_ready = $urandom_range(0, 99) < 75;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
